// File: rtl/wb_stream_master.sv
// -----------------------------------------------------------------------------
// wb_stream_master
//
// Host-side Wishbone initiator. Each val/rdy request becomes one classic
// Wishbone cycle, and the result comes back as a val/rdy response. Only one
// transaction is outstanding at a time. If the slave never acknowledges, the
// bus cycle is abandoned after TIMEOUT cycles and the response carries an
// error flag.
//
// Ports
//   clk        : single clock for the whole block
//   reset      : asynchronous, active-high reset
//   req_msg    : [68]=we, [67:36]=adr, [35:4]=wdata, [3:0]=sel
//   req_val    : request valid
//   req_rdy    : request ready (decoded from state only; high in IDLE)
//   resp_msg   : [32]=timeout error, [31:0]=read data (0 for writes)
//   resp_val   : response valid
//   resp_rdy   : response ready
//   wbm_cyc_o  : Wishbone cycle
//   wbm_stb_o  : Wishbone strobe
//   wbm_we_o   : Wishbone write enable
//   wbm_sel_o  : Wishbone byte selects
//   wbm_adr_o  : Wishbone address
//   wbm_dat_o  : Wishbone write data
//   wbm_dat_i  : Wishbone read data
//   wbm_ack_i  : Wishbone acknowledge
// -----------------------------------------------------------------------------
module wb_stream_master #(
    parameter int unsigned TIMEOUT = 64,
    parameter int unsigned CW      = $clog2(TIMEOUT + 1)
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [68:0] req_msg,
    input  logic        req_val,
    output logic        req_rdy,
    output logic [32:0] resp_msg,
    output logic        resp_val,
    input  logic        resp_rdy,
    output logic        wbm_cyc_o,
    output logic        wbm_stb_o,
    output logic        wbm_we_o,
    output logic [3:0]  wbm_sel_o,
    output logic [31:0] wbm_adr_o,
    output logic [31:0] wbm_dat_o,
    input  logic [31:0] wbm_dat_i,
    input  logic        wbm_ack_i
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUS  = 2'd1,
        ST_RESP = 2'd2
    } state_e;

    // Last counter value before the timeout fires: TIMEOUT BUS cycles in total.
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

    state_e        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          cyc_q, cyc_d;
    logic          we_q, we_d;
    logic [3:0]    sel_q, sel_d;
    logic [31:0]   adr_q, adr_d;
    logic [31:0]   dat_q, dat_d;
    logic          resp_val_q, resp_val_d;
    logic [32:0]   resp_msg_q, resp_msg_d;

    // Ready depends on state only, so there is no combinational req_val->req_rdy path.
    assign req_rdy   = (state_q == ST_IDLE);
    assign wbm_cyc_o = cyc_q;
    assign wbm_stb_o = cyc_q;
    assign wbm_we_o  = we_q;
    assign wbm_sel_o = sel_q;
    assign wbm_adr_o = adr_q;
    assign wbm_dat_o = dat_q;
    assign resp_val  = resp_val_q;
    assign resp_msg  = resp_msg_q;

    // Next-state and next-output logic for the IDLE -> BUS -> RESP sequence.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        cyc_d      = cyc_q;
        we_d       = we_q;
        sel_d      = sel_q;
        adr_d      = adr_q;
        dat_d      = dat_q;
        resp_val_d = resp_val_q;
        resp_msg_d = resp_msg_q;

        case (state_q)
            ST_IDLE: begin
                if (req_val) begin
                    state_d = ST_BUS;
                    cnt_d   = {CW{1'b0}};
                    cyc_d   = 1'b1;
                    we_d    = req_msg[68];
                    adr_d   = req_msg[67:36];
                    dat_d   = req_msg[35:4];
                    sel_d   = req_msg[3:0];
                end else begin
                    state_d = ST_IDLE;
                end
            end

            ST_BUS: begin
                // Ack takes priority over a timeout in the same cycle.
                if (wbm_ack_i) begin
                    state_d    = ST_RESP;
                    cyc_d      = 1'b0;
                    we_d       = 1'b0;
                    sel_d      = 4'h0;
                    adr_d      = 32'h0;
                    dat_d      = 32'h0;
                    resp_val_d = 1'b1;
                    resp_msg_d = {1'b0, (we_q ? 32'h0 : wbm_dat_i)};
                end else if (cnt_q == CNT_LAST) begin
                    state_d    = ST_RESP;
                    cyc_d      = 1'b0;
                    we_d       = 1'b0;
                    sel_d      = 4'h0;
                    adr_d      = 32'h0;
                    dat_d      = 32'h0;
                    resp_val_d = 1'b1;
                    resp_msg_d = {1'b1, 32'h0};
                end else begin
                    // Only incremented while below CNT_LAST, so it never wraps.
                    cnt_d = cnt_q + CW'(1);
                end
            end

            ST_RESP: begin
                if (resp_rdy) begin
                    state_d    = ST_IDLE;
                    resp_val_d = 1'b0;
                    resp_msg_d = 33'h0;
                end else begin
                    state_d = ST_RESP;
                end
            end

            default: begin
                state_d    = ST_IDLE;
                cnt_d      = {CW{1'b0}};
                cyc_d      = 1'b0;
                we_d       = 1'b0;
                sel_d      = 4'h0;
                adr_d      = 32'h0;
                dat_d      = 32'h0;
                resp_val_d = 1'b0;
                resp_msg_d = 33'h0;
            end
        endcase
    end

    // State and registered outputs; reset aborts any bus cycle immediately.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            cnt_q      <= {CW{1'b0}};
            cyc_q      <= 1'b0;
            we_q       <= 1'b0;
            sel_q      <= 4'h0;
            adr_q      <= 32'h0;
            dat_q      <= 32'h0;
            resp_val_q <= 1'b0;
            resp_msg_q <= 33'h0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            cyc_q      <= cyc_d;
            we_q       <= we_d;
            sel_q      <= sel_d;
            adr_q      <= adr_d;
            dat_q      <= dat_d;
            resp_val_q <= resp_val_d;
            resp_msg_q <= resp_msg_d;
        end
    end

endmodule

// File: tb/tb_wb_stream_master.sv
// -----------------------------------------------------------------------------
// tb_wb_stream_master
//
// Bench for wb_stream_master. A transaction-level model tracks whether the
// block should be idle, running a bus cycle (and how many bus cycles have
// elapsed), or holding a response. The DUT outputs are compared against that
// model on every falling edge. Directed scenarios also pin literal values,
// and a randomized phase exercises stalls, spurious acks and timeouts.
// -----------------------------------------------------------------------------
module tb_wb_stream_master;

    localparam int TIMEOUT = 64;

    logic        clk = 1'b0;
    logic        reset;
    logic [68:0] req_msg;
    logic        req_val;
    logic        req_rdy;
    logic [32:0] resp_msg;
    logic        resp_val;
    logic        resp_rdy;
    logic        wbm_cyc_o;
    logic        wbm_stb_o;
    logic        wbm_we_o;
    logic [3:0]  wbm_sel_o;
    logic [31:0] wbm_adr_o;
    logic [31:0] wbm_dat_o;
    logic [31:0] wbm_dat_i;
    logic        wbm_ack_i;

    always #5 clk = ~clk;

    wb_stream_master #(.TIMEOUT(TIMEOUT)) dut (
        .clk       (clk),
        .reset     (reset),
        .req_msg   (req_msg),
        .req_val   (req_val),
        .req_rdy   (req_rdy),
        .resp_msg  (resp_msg),
        .resp_val  (resp_val),
        .resp_rdy  (resp_rdy),
        .wbm_cyc_o (wbm_cyc_o),
        .wbm_stb_o (wbm_stb_o),
        .wbm_we_o  (wbm_we_o),
        .wbm_sel_o (wbm_sel_o),
        .wbm_adr_o (wbm_adr_o),
        .wbm_dat_o (wbm_dat_o),
        .wbm_dat_i (wbm_dat_i),
        .wbm_ack_i (wbm_ack_i)
    );

    int checks = 0;
    int errors = 0;

    // Model: 0 = idle, 1 = bus cycle running, 2 = response pending.
    int          m_phase;
    logic [68:0] m_req;
    int          m_cycles;
    logic [32:0] m_resp;

    task automatic chk(input string name, input logic [68:0] act, input logic [68:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h time=%0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_phase  = 0;
        m_req    = '0;
        m_cycles = 0;
        m_resp   = '0;
    endtask

    task automatic compare_outputs();
        chk("req_rdy",  69'(req_rdy),   69'(m_phase == 0));
        chk("cyc",      69'(wbm_cyc_o), 69'(m_phase == 1));
        chk("stb",      69'(wbm_stb_o), 69'(m_phase == 1));
        chk("we",       69'(wbm_we_o),  69'((m_phase == 1) ? m_req[68] : 1'b0));
        chk("adr",      69'(wbm_adr_o), 69'((m_phase == 1) ? m_req[67:36] : 32'h0));
        chk("dat_o",    69'(wbm_dat_o), 69'((m_phase == 1) ? m_req[35:4] : 32'h0));
        chk("sel",      69'(wbm_sel_o), 69'((m_phase == 1) ? m_req[3:0] : 4'h0));
        chk("resp_val", 69'(resp_val),  69'(m_phase == 2));
        if (m_phase == 2) begin
            chk("resp_msg", 69'(resp_msg), 69'(m_resp));
        end
    endtask

    // One clock cycle: check current outputs, apply inputs, advance the model
    // to what the outputs must be after the next rising edge.
    task automatic step(input logic rv, input logic [68:0] msg, input logic ack,
                        input logic [31:0] di, input logic rr);
        @(negedge clk);
        compare_outputs();
        req_val   = rv;
        req_msg   = msg;
        wbm_ack_i = ack;
        wbm_dat_i = di;
        resp_rdy  = rr;
        case (m_phase)
            0: begin
                if (rv) begin
                    m_req    = msg;
                    m_cycles = 0;
                    m_phase  = 1;
                end
            end
            1: begin
                m_cycles++;
                if (ack) begin
                    m_resp  = {1'b0, (m_req[68] ? 32'h0 : di)};
                    m_phase = 2;
                end else if (m_cycles == TIMEOUT) begin
                    m_resp  = {1'b1, 32'h0};
                    m_phase = 2;
                end
            end
            default: begin
                if (rr) m_phase = 0;
            end
        endcase
    endtask

    task automatic idle_step();
        step(1'b0, 69'h0, 1'b0, 32'h0, 1'b1);
    endtask

    // Bring the DUT back to idle with a bounded number of cycles.
    task automatic drain();
        int n = 0;
        while (m_phase != 0 && n < 200) begin
            step(1'b0, 69'h0, 1'b1, 32'h0BAD_F00D, 1'b1);
            n++;
        end
        chk("drain_bound", 69'(m_phase), 69'(0));
    endtask

    initial begin
        int          bus_cnt;
        logic [95:0] rnd;
        int          pct;

        reset     = 1'b1;
        req_val   = 1'b0;
        req_msg   = '0;
        resp_rdy  = 1'b0;
        wbm_ack_i = 1'b0;
        wbm_dat_i = 32'h0;
        model_reset();

        // Reset state.
        #1;
        chk("rst_req_rdy",  69'(req_rdy),   69'(1'b1));
        chk("rst_cyc",      69'(wbm_cyc_o), 69'(1'b0));
        chk("rst_stb",      69'(wbm_stb_o), 69'(1'b0));
        chk("rst_adr",      69'(wbm_adr_o), 69'(32'h0));
        chk("rst_resp_val", 69'(resp_val),  69'(1'b0));
        chk("rst_resp_msg", 69'(resp_msg),  69'(33'h0));
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;

        // 1: write, acked two cycles after the bus cycle starts.
        step(1'b1, {1'b1, 32'h3000_0000, 32'hDEAD_BEEF, 4'hF}, 1'b0, 32'h0, 1'b0);
        step(1'b0, 69'h0, 1'b0, 32'h0, 1'b0);
        chk("t1_cyc", 69'(wbm_cyc_o), 69'(1'b1));
        chk("t1_we",  69'(wbm_we_o),  69'(1'b1));
        chk("t1_adr", 69'(wbm_adr_o), 69'(32'h3000_0000));
        chk("t1_dat", 69'(wbm_dat_o), 69'(32'hDEAD_BEEF));
        chk("t1_sel", 69'(wbm_sel_o), 69'(4'hF));
        step(1'b0, 69'h0, 1'b1, 32'h5555_AAAA, 1'b0);
        step(1'b0, 69'h0, 1'b0, 32'h0, 1'b1);
        chk("t1_resp_val", 69'(resp_val),  69'(1'b1));
        chk("t1_resp_msg", 69'(resp_msg),  69'(33'h0));
        chk("t1_cyc_off",  69'(wbm_cyc_o), 69'(1'b0));
        idle_step();

        // 2: read acked in the first bus cycle.
        step(1'b1, {1'b0, 32'h3000_0004, 32'h0, 4'hF}, 1'b0, 32'h0, 1'b0);
        step(1'b0, 69'h0, 1'b1, 32'h1234_5678, 1'b0);
        chk("t2_rdy_bus", 69'(req_rdy), 69'(1'b0));
        step(1'b0, 69'h0, 1'b0, 32'h0, 1'b1);
        chk("t2_resp_val", 69'(resp_val), 69'(1'b1));
        chk("t2_resp_msg", 69'(resp_msg), 69'({1'b0, 32'h1234_5678}));
        chk("t2_rdy_resp", 69'(req_rdy),  69'(1'b0));
        idle_step();
        chk("t2_rdy_idle", 69'(req_rdy), 69'(1'b1));

        // 3a: read with no ack times out after exactly TIMEOUT bus cycles.
        step(1'b1, {1'b0, 32'h3000_0008, 32'h0, 4'h3}, 1'b0, 32'h0, 1'b0);
        bus_cnt = 0;
        for (int i = 0; i < TIMEOUT; i++) begin
            step(1'b0, 69'h0, 1'b0, 32'h0, 1'b0);
            if (wbm_cyc_o) bus_cnt++;
        end
        step(1'b0, 69'h0, 1'b0, 32'h0, 1'b1);
        chk("t3_bus_cycles", 69'(bus_cnt),   69'(64));
        chk("t3_cyc_off",    69'(wbm_cyc_o), 69'(1'b0));
        chk("t3_resp_msg",   69'(resp_msg),  69'({1'b1, 32'h0}));
        idle_step();

        // 3b: ack in the last allowed bus cycle wins over the timeout.
        step(1'b1, {1'b0, 32'h3000_000C, 32'h0, 4'hF}, 1'b0, 32'h0, 1'b0);
        for (int i = 0; i < TIMEOUT - 1; i++) begin
            step(1'b0, 69'h0, 1'b0, 32'h0, 1'b0);
        end
        step(1'b0, 69'h0, 1'b1, 32'hA5A5_5A5A, 1'b0);
        step(1'b0, 69'h0, 1'b0, 32'h0, 1'b1);
        chk("t3_ack_last", 69'(resp_msg), 69'({1'b0, 32'hA5A5_5A5A}));
        idle_step();

        // 4: response back-pressure with ignored request pulses.
        step(1'b1, {1'b0, 32'h3000_0010, 32'h0, 4'hF}, 1'b0, 32'h0, 1'b0);
        step(1'b0, 69'h0, 1'b1, 32'hCAFE_F00D, 1'b0);
        for (int i = 0; i < 10; i++) begin
            step(1'(i % 2), {1'b1, 32'h4000_0000, 32'h1111_2222, 4'h1}, 1'b0, 32'h0, 1'b0);
        end
        step(1'b0, 69'h0, 1'b0, 32'h0, 1'b1);
        chk("t4_resp_held", 69'(resp_msg), 69'({1'b0, 32'hCAFE_F00D}));
        step(1'b1, {1'b1, 32'h3000_0014, 32'h0F0F_0F0F, 4'hC}, 1'b0, 32'h0, 1'b1);
        step(1'b0, 69'h0, 1'b1, 32'h0, 1'b1);
        chk("t4_next_adr", 69'(wbm_adr_o), 69'(32'h3000_0014));
        drain();

        // 5: spurious acks while idle and while a response is pending.
        for (int i = 0; i < 3; i++) step(1'b0, 69'h0, 1'b1, 32'hFFFF_FFFF, 1'b1);
        step(1'b1, {1'b0, 32'h3000_0018, 32'h0, 4'hF}, 1'b0, 32'h0, 1'b0);
        step(1'b0, 69'h0, 1'b1, 32'h7777_8888, 1'b0);
        for (int i = 0; i < 3; i++) step(1'b0, 69'h0, 1'b1, 32'h9999_0000, 1'b0);
        step(1'b0, 69'h0, 1'b0, 32'h0, 1'b1);
        chk("t5_resp_msg", 69'(resp_msg), 69'({1'b0, 32'h7777_8888}));
        idle_step();

        // 6: reset asserted in the third bus cycle aborts the transaction.
        step(1'b1, {1'b1, 32'h3000_001C, 32'h1357_9BDF, 4'hF}, 1'b0, 32'h0, 1'b1);
        step(1'b0, 69'h0, 1'b0, 32'h0, 1'b1);
        step(1'b0, 69'h0, 1'b0, 32'h0, 1'b1);
        step(1'b0, 69'h0, 1'b0, 32'h0, 1'b1);
        #1 reset = 1'b1;
        #1;
        chk("t6_cyc",      69'(wbm_cyc_o), 69'(1'b0));
        chk("t6_stb",      69'(wbm_stb_o), 69'(1'b0));
        chk("t6_resp_val", 69'(resp_val),  69'(1'b0));
        chk("t6_req_rdy",  69'(req_rdy),   69'(1'b1));
        model_reset();
        @(posedge clk);
        #1 reset = 1'b0;
        for (int i = 0; i < 3; i++) idle_step();
        step(1'b1, {1'b1, 32'h3000_0020, 32'h2468_ACE0, 4'h5}, 1'b0, 32'h0, 1'b1);
        step(1'b0, 69'h0, 1'b1, 32'h0, 1'b1);
        step(1'b0, 69'h0, 1'b0, 32'h0, 1'b1);
        chk("t6_write_resp", 69'(resp_msg), 69'(33'h0));
        idle_step();

        // Randomized traffic with varying ack likelihood (0% forces timeouts).
        for (int seg = 0; seg < 4; seg++) begin
            case (seg)
                0:       pct = 30;
                1:       pct = 5;
                2:       pct = 0;
                default: pct = 60;
            endcase
            for (int i = 0; i < 500; i++) begin
                rnd = {$urandom(), $urandom(), $urandom()};
                step(1'($urandom_range(0, 1)), rnd[68:0],
                     1'($urandom_range(0, 99) < pct), $urandom(),
                     1'($urandom_range(0, 2) != 0));
            end
        end
        drain();
        idle_step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
